// File: rtl/alu_seq_if.sv
// Handshake and data bundle between the execute-stage pipeline and alu_seq.
// The ALU connects through the slave modport; the pipeline drives the master side.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             ovf_o;
    logic             valid_o;

    modport master (
        output valid_i,
        output src1_i,
        output src2_i,
        output ctrl_i,
        input  ready_o,
        input  result_o,
        input  zero_o,
        input  ovf_o,
        input  valid_o
    );

    modport slave (
        input  valid_i,
        input  src1_i,
        input  src2_i,
        input  ctrl_i,
        output ready_o,
        output result_o,
        output zero_o,
        output ovf_o,
        output valid_o
    );
endinterface

// File: rtl/alu_seq.sv
// Clocked execute-stage ALU: single-cycle logic/arith/shift/compare ops plus
// iterative shift-add multiply and restoring divide (WIDTH steps each).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a new op; single-cycle ops complete here
// MUL    | one shift-add step per clock, count down from WIDTH
// DIV    | one restoring shift-subtract step per clock, count down
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk_i,
    input  logic     rst_i,
    alu_seq_if.slave bus
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    localparam int         MSB      = WIDTH - 1;
    localparam logic [SHW:0] CNT_INIT = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [SHW:0]     cnt_q,    cnt_d;
    logic             is_rem_q, is_rem_d;
    // a: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV)
    logic [WIDTH-1:0] a_q,      a_d;
    // b: multiplier (MUL) or divisor (DIV)
    logic [WIDTH-1:0] b_q,      b_d;
    // acc: product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;
    logic             valid_q,  valid_d;

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic [WIDTH-1:0] mul_acc_step;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_step;
    logic [WIDTH-1:0] div_quo_step;
    logic [WIDTH-1:0] iter_res;

    // Single-cycle datapath, evaluated on the live operand inputs.
    always_comb begin
        add_res = bus.src1_i + bus.src2_i;
        sub_res = bus.src1_i - bus.src2_i;
        shamt   = bus.src2_i[SHW-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ctrl_i)
            OP_AND:  alu_res = bus.src1_i & bus.src2_i;
            OP_OR:   alu_res = bus.src1_i | bus.src2_i;
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (bus.src1_i[MSB] == bus.src2_i[MSB]) &&
                          (add_res[MSB] != bus.src1_i[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (bus.src1_i[MSB] != bus.src2_i[MSB]) &&
                          (sub_res[MSB] != bus.src1_i[MSB]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(bus.src1_i) < $signed(bus.src2_i))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.src1_i < bus.src2_i)};
            OP_NOR:  alu_res = ~(bus.src1_i | bus.src2_i);
            OP_XOR:  alu_res = bus.src1_i ^ bus.src2_i;
            OP_SLL:  alu_res = bus.src1_i << shamt;
            OP_SRL:  alu_res = bus.src1_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.src1_i) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // One iteration of multiply and divide on the latched operands.
    always_comb begin
        mul_acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
        // Remainder is widened by one bit so the compare sees the shifted-in MSB;
        // after a successful subtract the true difference is below the divisor,
        // so the low WIDTH bits of the modular difference are exact.
        rem_sh       = {acc_q, a_q[MSB]};
        div_ge       = (rem_sh >= {1'b0, b_q});
        div_rem_step = div_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        div_quo_step = {a_q[WIDTH-2:0], div_ge};
        iter_res     = is_rem_q ? div_rem_step : div_quo_step;
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_rem_d = is_rem_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.valid_i) begin
                    case (bus.ctrl_i)
                        OP_MUL: begin
                            a_d     = bus.src1_i;
                            b_d     = bus.src2_i;
                            acc_d   = '0;
                            cnt_d   = CNT_INIT;
                            state_d = S_MUL;
                        end
                        OP_DIVU, OP_REMU: begin
                            a_d      = bus.src1_i;
                            b_d      = bus.src2_i;
                            acc_d    = '0;
                            is_rem_d = (bus.ctrl_i == OP_REMU);
                            cnt_d    = CNT_INIT;
                            state_d  = S_DIV;
                        end
                        default: begin
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            ovf_d    = alu_ovf;
                            valid_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_acc_step;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    result_d = mul_acc_step;
                    zero_d   = (mul_acc_step == '0);
                    ovf_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = div_rem_step;
                a_d   = div_quo_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    result_d = iter_res;
                    zero_d   = (iter_res == '0);
                    ovf_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any iterative op in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.ready_o  = (state_q == S_IDLE);
    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.valid_o  = valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH = 32: inputs change and outputs are
// sampled on the falling edge, midway between active edges.
module tb_alu_seq;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    logic clk_i;
    logic rst_i;
    int   checks;
    int   errors;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a single-cycle op, let one edge accept it, then check outputs.
    task automatic single(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_z,
                          input logic exp_o);
        bus.valid_i = 1'b1;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        check({tag, " result"}, bus.result_o, exp_res);
        check({tag, " zero"},   {31'd0, bus.zero_o}, {31'd0, exp_z});
        check({tag, " ovf"},    {31'd0, bus.ovf_o},  {31'd0, exp_o});
        check({tag, " valid"},  {31'd0, bus.valid_o}, 32'd1);
    endtask

    // Run an iterative op and measure latency / ready-low cycles.
    task automatic multi(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit poke);
        int lat;
        int low;
        bus.valid_i = 1'b1;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        lat = 0;
        low = 0;
        while (!bus.valid_o && lat < 40) begin
            if (!bus.ready_o) low++;
            if (poke && lat == 10) begin
                bus.valid_i = 1'b1;
                bus.ctrl_i  = OP_ADD;
                bus.src1_i  = 32'd1;
                bus.src2_i  = 32'd2;
            end else begin
                bus.valid_i = 1'b0;
                bus.src1_i  = $urandom;
                bus.src2_i  = $urandom;
            end
            @(negedge clk_i);
            lat++;
        end
        bus.valid_i = 1'b0;
        check({tag, " completed"}, {31'd0, bus.valid_o}, 32'd1);
        check({tag, " latency"},   lat, 32'd32);
        check({tag, " ready low"}, low, 32'd32);
        check({tag, " ready back"}, {31'd0, bus.ready_o}, 32'd1);
        check({tag, " result"},    bus.result_o, exp_res);
        check({tag, " zero"},      {31'd0, bus.zero_o}, {31'd0, (exp_res == 32'd0)});
        check({tag, " ovf"},       {31'd0, bus.ovf_o}, 32'd0);
        @(negedge clk_i);
        check({tag, " pulse"},     {31'd0, bus.valid_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst_i       = 1'b1;
        bus.valid_i = 1'b0;
        bus.ctrl_i  = 4'd0;
        bus.src1_i  = 32'd0;
        bus.src2_i  = 32'd0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        check("reset result", bus.result_o, 32'd0);
        check("reset zero",   {31'd0, bus.zero_o},  32'd1);
        check("reset ovf",    {31'd0, bus.ovf_o},   32'd0);
        check("reset valid",  {31'd0, bus.valid_o}, 32'd0);
        check("reset ready",  {31'd0, bus.ready_o}, 32'd1);

        // Signed overflow on ADD, then valid_o must drop.
        single("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clk_i);
        check("add pulse", {31'd0, bus.valid_o}, 32'd0);
        check("add hold",  bus.result_o, 32'h8000_0000);

        // Back-to-back single-cycle ops.
        single("sub zero", OP_SUB,  32'd5,         32'd5,  32'h0,         1'b1, 1'b0);
        single("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1,  32'h1,         1'b0, 1'b0);
        single("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1,  32'h0,         1'b1, 1'b0);
        single("sra",      OP_SRA,  32'h8000_0000, 32'd4,  32'hF800_0000, 1'b0, 1'b0);
        single("sub ovf",  OP_SUB,  32'h8000_0000, 32'd1,  32'h7FFF_FFFF, 1'b0, 1'b1);
        single("sub nov",  OP_SUB,  32'd3,         32'd5,  32'hFFFF_FFFE, 1'b0, 1'b0);
        single("add nov",  OP_ADD,  32'hFFFF_FFFF, 32'd1,  32'h0,         1'b1, 1'b0);
        single("and",      OP_AND,  32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034, 1'b0, 1'b0);
        single("or",       OP_OR,   32'hF0F0_0000, 32'h0F00_0001, 32'hFFF0_0001, 1'b0, 1'b0);
        single("nor",      OP_NOR,  32'h0,         32'h0,  32'hFFFF_FFFF, 1'b0, 1'b0);
        single("xor",      OP_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0);
        single("sll",      OP_SLL,  32'h1,         32'd31, 32'h8000_0000, 1'b0, 1'b0);
        single("sll mask", OP_SLL,  32'h1,         32'h21, 32'h2,         1'b0, 1'b0);
        single("srl",      OP_SRL,  32'h8000_0000, 32'd4,  32'h0800_0000, 1'b0, 1'b0);
        single("slt pos",  OP_SLT,  32'd1,         32'hFFFF_FFFF, 32'h0,  1'b1, 1'b0);
        single("sltu lt",  OP_SLTU, 32'd1,         32'hFFFF_FFFF, 32'h1,  1'b0, 1'b0);
        // Reserved opcode right after an overflowing ADD so ovf must clear.
        single("add ovf2", OP_ADD,  32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 1'b0, 1'b1);
        single("op1110",   4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,  1'b1, 1'b0);
        single("op1111",   4'b1111, 32'hFFFF_FFFF, 32'h1,  32'h0,         1'b1, 1'b0);
        @(negedge clk_i);

        // Iterative ops; a request mid-multiply must be ignored.
        multi("mul",       OP_MUL,  32'h0001_0003, 32'd5,         32'h0005_000F, 1'b1);
        multi("mul neg",   OP_MUL,  32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 1'b0);
        multi("mul wrap",  OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0,         1'b0);
        multi("divu",      OP_DIVU, 32'd100,       32'd7,         32'd14,        1'b1);
        multi("remu",      OP_REMU, 32'd100,       32'd7,         32'd2,         1'b0);
        multi("divu by0",  OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0);
        multi("remu by0",  OP_REMU, 32'd9,         32'd0,         32'd9,         1'b0);
        multi("divu big",  OP_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 1'b0);

        // Reset partway through a divide aborts it.
        bus.valid_i = 1'b1;
        bus.ctrl_i  = OP_DIVU;
        bus.src1_i  = 32'd1000;
        bus.src2_i  = 32'd3;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("abort busy", {31'd0, bus.ready_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort valid",  {31'd0, bus.valid_o}, 32'd0);
        check("abort result", bus.result_o, 32'd0);
        check("abort ready",  {31'd0, bus.ready_o}, 32'd1);
        check("abort zero",   {31'd0, bus.zero_o},  32'd1);
        single("post rst add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
        repeat (35) begin
            @(negedge clk_i);
            check("no stale div", {31'd0, bus.valid_o}, 32'd0);
        end
        check("stale result", bus.result_o, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
